display_scanner: RTL



---
 rtl/display_scanner_pkg.sv | 26 ++
 rtl/display_scanner_bcd_to_seg7.sv | 30 +++
 rtl/display_scanner.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/display_scanner_pkg.sv
// display_scanner_pkg
// Shared constants for the 7-segment display scanner.
//   - NDIG_DEFAULT : default number of scanned digits
//   - OFF_LEVEL    : electrical level that turns an LED off (display is
//                    common-anode, so every output is active-low)
//   - SEG_*        : glyphs in {g,f,e,d,c,b,a} order, active-low
package display_scanner_pkg;

    localparam int NDIG_DEFAULT = 4;

    localparam logic OFF_LEVEL = 1'b1;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/display_scanner_bcd_to_seg7.sv
// bcd_to_seg7
// Purely combinational BCD to 7-segment decoder (active-low segments).
// Ports:
//   bcd : input  [3:0] digit value; 10..15 decode to a dash
//   seg : output [6:0] segments {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
    import display_scanner_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scanner.sv
// display_scanner
// Time-multiplexes NDIG BCD digits onto a common-anode 7-segment display.
// The divided square wave on tick_in is sampled as data; each rising edge
// advances the scan by one digit. Values are double buffered: loads land in
// a pending buffer that is copied to the display buffer only when the scan
// wraps, so a frame never shows a mix of old and new digits.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros
// (digit 0 is never blanked, blanked digits keep their anode and dp).
//
// Ports:
//   clock_in   : system clock, all logic on posedge
//   reset      : synchronous, active-high reset
//   tick_in    : divided clock, rising edge = advance one digit
//   value_in   : NDIG packed BCD digits, digit 0 in bits [3:0]
//   dp_in      : decimal-point request per digit
//   load_in    : strobe capturing value_in/dp_in into the pending buffer
//   anode_out  : active-low digit enables, one-hot-low while scanning
//   seg_out    : active-low segments {g,f,e,d,c,b,a}
//   dp_out     : active-low decimal point
//   frame_done : one-cycle pulse when the scan wraps to digit 0
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int NDIG = NDIG_DEFAULT,
    parameter int IDXW = 2
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              tick_in,
    input  logic [4*NDIG-1:0] value_in,
    input  logic [NDIG-1:0]   dp_in,
    input  logic              load_in,
    output logic [NDIG-1:0]   anode_out,
    output logic [6:0]        seg_out,
    output logic              dp_out,
    output logic              frame_done
);

    logic              tick_q;
    logic              scanning;
    logic [IDXW-1:0]   idx;
    logic [4*NDIG-1:0] pend_value;
    logic [NDIG-1:0]   pend_dp;
    logic [4*NDIG-1:0] disp_value;
    logic [NDIG-1:0]   disp_dp;

    logic              step;
    logic              wrap;
    logic [IDXW-1:0]   next_idx;
    logic [4*NDIG-1:0] next_value;
    logic [NDIG-1:0]   next_dp;
    logic [3:0]        digit;
    logic              digit_dp;
    logic              digit_blank;
    logic [NDIG-1:0]   anode_next;
    logic [NDIG-1:0]   blank_mask;
    logic [6:0]        glyph;
    logic [6:0]        seg_next;

    // Step/wrap detection and next index. The first step after reset only
    // starts scanning on digit 0; it is not a wrap and does not advance idx.
    // Outputs are decoded from the buffer contents as they will be after
    // this edge, so the first digit of a new frame already shows new data.
    always_comb begin
        step       = tick_in & ~tick_q;
        wrap       = step & scanning & (idx == IDXW'(NDIG - 1));
        next_idx   = idx;
        next_value = disp_value;
        next_dp    = disp_dp;
        if (step) begin
            next_idx = (!scanning || wrap) ? '0 : idx + IDXW'(1);
        end
        if (wrap) begin
            if (load_in) begin
                next_value = value_in;
                next_dp    = dp_in;
            end else begin
                next_value = pend_value;
                next_dp    = pend_dp;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every digit above it are zero.
    always_comb begin
        logic zero_run;
        zero_run   = 1'b1;
        blank_mask = '0;
        for (int k = NDIG - 1; k > 0; k--) begin
            zero_run      = zero_run & (next_value[4*k +: 4] == 4'd0);
            blank_mask[k] = zero_run;
        end
    end
`else
    assign blank_mask = '0;
`endif

    // Digit mux and one-hot-low anode for the upcoming index.
    always_comb begin
        digit       = 4'd0;
        digit_dp    = 1'b0;
        digit_blank = 1'b0;
        anode_next  = {NDIG{OFF_LEVEL}};
        for (int k = 0; k < NDIG; k++) begin
            if (next_idx == IDXW'(k)) begin
                digit         = next_value[4*k +: 4];
                digit_dp      = next_dp[k];
                digit_blank   = blank_mask[k];
                anode_next[k] = ~OFF_LEVEL;
            end
        end
    end

    bcd_to_seg7 u_decode (
        .bcd (digit),
        .seg (glyph)
    );

    always_comb begin
        seg_next = digit_blank ? SEG_BLANK : glyph;
    end

    // State and output registers; outputs only change on a step.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            tick_q     <= 1'b1;
            scanning   <= 1'b0;
            idx        <= '0;
            pend_value <= '0;
            pend_dp    <= '0;
            disp_value <= '0;
            disp_dp    <= '0;
            anode_out  <= {NDIG{OFF_LEVEL}};
            seg_out    <= SEG_BLANK;
            dp_out     <= OFF_LEVEL;
            frame_done <= 1'b0;
        end else begin
            tick_q     <= tick_in;
            frame_done <= wrap;
            disp_value <= next_value;
            disp_dp    <= next_dp;
            if (load_in) begin
                pend_value <= value_in;
                pend_dp    <= dp_in;
            end
            if (step) begin
                scanning  <= 1'b1;
                idx       <= next_idx;
                anode_out <= anode_next;
                seg_out   <= seg_next;
                dp_out    <= ~digit_dp;
            end
        end
    end

endmodule
